// File: rtl/arbitro_mux4.sv
// arbitro_mux4: round-robin arbiter that drives the seletor of a shared mux4_1.
// Define ARB_TIMEOUT_EN to force a release after MAX_CICLOS consecutive grant cycles.
module arbitro_mux4 #(
  parameter int PRIORIDADE_INICIAL = 0,
  parameter int MAX_CICLOS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] requisicao,
  output logic [3:0] concessao,
  output logic [1:0] seletor,
  output logic       ocupado
);
  typedef enum logic {OCIOSO, CONCEDIDO} estado_t;
  estado_t estado, estado_n;
  logic [1:0] ptr, ptr_n, sel_n, base, win;
  logic [3:0] conc_n;
  logic rel, novo, expira;
  if (MAX_CICLOS < 2 || MAX_CICLOS > 255) begin : g_chk
    $error("MAX_CICLOS out of range 2..255");
  end
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] b);
    logic [1:0] w;
    w = b;
    for (int k = 3; k >= 0; k--) w = r[b + 2'(k)] ? b + 2'(k) : w;
    return w;
  endfunction
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign expira = cnt == 8'(MAX_CICLOS - 1);
  always_ff @(posedge clock)
    if (!reset) cnt <= '0;
    else cnt <= novo ? '0 : cnt + 8'd1;
`else
  assign expira = 1'b0;
`endif
  always_comb begin
    rel = estado == CONCEDIDO && (!requisicao[seletor] || expira);
    novo = estado == OCIOSO || rel;
    base = rel ? seletor + 2'd1 : ptr;
    win = pick(requisicao, base);
    ptr_n = base;
    estado_n = novo ? (|requisicao ? CONCEDIDO : OCIOSO) : estado;
    conc_n = novo ? (|requisicao ? 4'b0001 << win : 4'b0000) : concessao;
    sel_n = novo && |requisicao ? win : seletor;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      estado <= OCIOSO;
      ptr <= 2'(PRIORIDADE_INICIAL);
      seletor <= 2'd0;
      concessao <= 4'b0000;
    end else begin
      estado <= estado_n;
      ptr <= ptr_n;
      seletor <= sel_n;
      concessao <= conc_n;
    end
  assign ocupado = |concessao;
endmodule

// File: doc/arbitro_mux4.md
Name: arbitro_mux4

Overview:
- Round-robin arbiter that shares one 4-input multiplexer between four requesters.
- Accepts 4 request lines and issues a registered one-hot grant.
- Drives the 2-bit `seletor` that steers the shared mux4_1 instance, so the granted requester's data reaches the shared output.
- Sits between the requesting units and the shared mux; the mux datapath itself is unchanged.

Parameters:
- PRIORIDADE_INICIAL, 0, index (0..3) loaded into the round-robin pointer at reset.
- MAX_CICLOS, 16, maximum consecutive grant cycles per holder. Used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- requisicao  input  4  request lines; bit i = requester i wants the shared mux.
- concessao  output  4  one-hot grant, registered; all-zero when idle.
- seletor  output  2  index of granted requester; connect to mux4_1 seletor.
- ocupado  output  1  1 while any grant is active (equals OR of concessao).

Behaviour:
- Reset (reset==0 at rising edge):
  - concessao=4'b0000, seletor=2'b00, ocupado=0.
  - Pointer=PRIORIDADE_INICIAL, state=OCIOSO, hold counter=0.
  - Reset dominates every other input, including mid-grant; the active grant is dropped on that edge.
- Winner selection: first set bit of requisicao, scanning pointer, pointer+1, ... modulo 4 (3 wraps to 0).
- State OCIOSO:
  - If requisicao!=0: on the next edge, concessao=onehot(winner), seletor=winner, ocupado=1, go to CONCEDIDO.
  - Grant latency: exactly 1 cycle from request sampled to grant visible.
  - If requisicao==0: stay OCIOSO; seletor keeps its last value so the mux output stays stable.
- State CONCEDIDO:
  - Grant held while requisicao[seletor]==1.
  - Other requests never preempt the holder.
  - Release occurs on the edge where requisicao[seletor]==0 is sampled:
    - Pointer <= seletor+1 (mod 4).
    - If any request remains, grant the winner from the new pointer on the same edge. No idle cycle; ocupado stays 1; counter=0.
    - Otherwise: concessao=0, ocupado=0, seletor unchanged, go to OCIOSO.
- Invariants:
  - concessao is always zero or one-hot.
  - concessao[seletor]==ocupado.
  - Grants change only on clock edges.
- Simultaneous requests in OCIOSO: the pointer decides; after reset with PRIORIDADE_INICIAL=0, requester 0 wins first.
- Requester re-asserting on the cycle after its release: treated as a new request at the lowest rotation priority relative to the others.
- Fairness: with all four requesting continuously and each releasing after N cycles, service order rotates 0,1,2,3,0,...

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (8 bits) increments each CONCEDIDO cycle and clears on every new grant.
  - When counter==MAX_CICLOS-1 and the holder is still requesting, a forced release occurs on the next edge: pointer advances past the holder and the winner is regranted as in normal release.
  - If the holder is the only requester, it is regranted with the counter cleared. concessao stays high continuously, with no glitch.
- Not defined: no counter logic; grants are held indefinitely; MAX_CICLOS is ignored.

Test Plan:
- Reset, then requisicao=4'b0100 → 1 cycle later concessao=4'b0100, seletor=2, ocupado=1. Drop the request → next edge concessao=0, ocupado=0, seletor stays 2.
- After reset (PRIORIDADE_INICIAL=0), requisicao=4'b1111 held, each holder releasing after 3 cycles → grants 0,1,2,3,0 back-to-back, no idle cycle, each exactly 3 cycles.
- Holder 1 granted, requester 3 asserts mid-grant → no preemption. On holder 1 release, 3 is granted on the same edge.
- reset=0 asserted while concessao=4'b0010 → next edge all outputs zero and pointer=PRIORIDADE_INICIAL. Re-request 4'b0011 after reset → requester 0 wins.
- ARB_TIMEOUT_EN, MAX_CICLOS=4, requisicao=4'b0011 held → grant alternates 0,1,0,... every 4 cycles. With only 4'b0001 held, concessao stays 4'b0001 continuously.
- Pointer wrap: holder 3 releases while requisicao=4'b0101 → requester 0 granted (scan 0 first, not 2).
